// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - Avalon-MM slave driving an HD44780 character LCD bus
//
// One Avalon read or write becomes one (8-bit bus) or two (4-bit bus,
// high nibble first) SETUP/PULSE/HOLD strobe sequences on the LCD pins.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   address[1:0]          bit1 = RS (data register); bit0 mirrors RW (direction
//                         is taken from read/write)
//   read, write           Avalon requests (both high is treated as a write)
//   writedata[7:0]        byte to LCD
//   readdata[7:0]         byte read from LCD, registered
//   waitrequest           Avalon stall, combinational
//   LCD_E, LCD_RS, LCD_RW LCD control strobes
//   LCD_data_out[7:0]     data towards the pads (nibble on [7:4] when BUS4=1)
//   LCD_data_oe           pad output enable for the top-level tristate
//   LCD_data_in[7:0]      data from the pads
module lcd_hd44780_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2,
  parameter bit BUS4      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [7:0] LCD_data_in
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  // Counter runs from CYC-1 down to 0, so it never needs to hold MAX_CYC itself.
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            nib, nib_d;     // 0 = first (high) nibble, 1 = second
  logic [3:0]      wr_low;         // low nibble kept for the second 4-bit write
  logic            req;
  logic            accept;
  logic            cnt_zero;
  logic            last_nib;
  logic            done;
  logic            unused_addr0;

  assign req       = read | write;
  assign accept    = (state == ST_IDLE) && req;
  assign cnt_zero  = (cnt == '0);
  assign last_nib  = BUS4 ? nib : 1'b1;
  assign done      = (state == ST_HOLD) && cnt_zero && last_nib;
  // Reset term keeps the stall asserted while in reset even if the FSM is
  // sitting on its completing cycle.
  assign waitrequest = req & (reset | ~done);

  assign LCD_E       = (state == ST_PULSE);
  assign LCD_data_oe = (state != ST_IDLE) & ~LCD_RW;

  // Direction comes from read/write; address[0] carries no extra information.
  assign unused_addr0 = address[0];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    nib_d   = nib;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          nib_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          if (last_nib) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            nib_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      nib          <= 1'b0;
      wr_low       <= 4'h0;
      LCD_RS       <= 1'b0;
      LCD_RW       <= 1'b1;
      LCD_data_out <= 8'h00;
      readdata     <= 8'h00;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      nib   <= nib_d;

      if (accept) begin
        LCD_RS <= address[1];
        LCD_RW <= ~write;
        wr_low <= writedata[3:0];
        if (write) begin
          LCD_data_out <= BUS4 ? {writedata[7:4], 4'h0} : writedata;
        end
      end

      // Switch to the low nibble exactly at the second SETUP entry.
      if ((state == ST_HOLD) && cnt_zero && !last_nib && !LCD_RW) begin
        LCD_data_out <= {wr_low, 4'h0};
      end

      // Sample on the last PULSE cycle so data is taken while E is still high.
      if ((state == ST_PULSE) && cnt_zero && LCD_RW) begin
        if (!BUS4) begin
          readdata <= LCD_data_in;
        end else if (!nib) begin
          readdata[7:4] <= LCD_data_in[7:4];
        end else begin
          readdata[3:0] <= LCD_data_in[7:4];
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - bench for lcd_hd44780_ctrl (8-bit and 4-bit instances)
module tb_lcd_hd44780_ctrl;

  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int T = S + P + H;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd [2];
  logic       wr [2];
  logic [1:0] addr [2];
  logic [7:0] wd [2];
  logic [7:0] din [2];
  logic [7:0] rdata [2];
  logic [7:0] dout [2];
  logic       waitr [2];
  logic       e [2];
  logic       rs [2];
  logic       rw [2];
  logic       oe [2];

  int checks = 0;
  int errors = 0;
  int k = 0;
  int ehigh = 0;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .BUS4(1'b0)) dut0 (
    .clk(clk), .reset(reset), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wd[0]), .readdata(rdata[0]), .waitrequest(waitr[0]),
    .LCD_E(e[0]), .LCD_RS(rs[0]), .LCD_RW(rw[0]), .LCD_data_out(dout[0]),
    .LCD_data_oe(oe[0]), .LCD_data_in(din[0])
  );

  lcd_hd44780_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .BUS4(1'b1)) dut1 (
    .clk(clk), .reset(reset), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wd[1]), .readdata(rdata[1]), .waitrequest(waitr[1]),
    .LCD_E(e[1]), .LCD_RS(rs[1]), .LCD_RW(rw[1]), .LCD_data_out(dout[1]),
    .LCD_data_oe(oe[1]), .LCD_data_in(din[1])
  );

  task automatic chk8(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d k=%0d actual=%02h expected=%02h", nm, i, k, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d k=%0d actual=%b expected=%b", nm, i, k, act, exp);
    end
  endtask

  // Behavioural model: an access occupies cycles 1..L after acceptance,
  // made of T-cycle segments (SETUP S, E high P, HOLD H).
  logic       m_busy [2];
  int         m_k [2];
  logic       m_wr [2];
  logic       m_rs [2];
  logic       m_rw [2];
  logic [7:0] m_data [2];
  logic [7:0] m_last [2];
  logic [7:0] m_rd [2];
  logic       started = 1'b0;

  function automatic int acc_len(input int i);
    return (i == 1) ? 2 * T : T;
  endfunction

  function automatic logic [7:0] seg_dout(input int i, input int kk);
    if (i == 0) return m_data[i];
    if ((kk - 1) / T == 0) return {m_data[i][7:4], 4'h0};
    return {m_data[i][3:0], 4'h0};
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] <= 1'b0;
        m_k[i]    <= 0;
        m_wr[i]   <= 1'b0;
        m_rs[i]   <= 1'b0;
        m_rw[i]   <= 1'b1;
        m_last[i] <= 8'h00;
        m_rd[i]   <= 8'h00;
      end else if (!m_busy[i]) begin
        if (rd[i] | wr[i]) begin
          m_busy[i] <= 1'b1;
          m_k[i]    <= 1;
          m_wr[i]   <= wr[i];
          m_rw[i]   <= !wr[i];
          m_rs[i]   <= addr[i][1];
          m_data[i] <= wd[i];
        end
      end else begin
        if (!m_wr[i] && ((m_k[i] - 1) % T == S + P - 1)) begin
          if (i == 0) m_rd[i] <= din[i];
          else if ((m_k[i] - 1) / T == 0) m_rd[i][7:4] <= din[i][7:4];
          else m_rd[i][3:0] <= din[i][7:4];
        end
        if (m_k[i] == acc_len(i)) begin
          m_busy[i] <= 1'b0;
          if (m_wr[i]) m_last[i] <= seg_dout(i, m_k[i]);
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int off;
        logic exp_e, exp_w;
        logic [7:0] exp_d;
        off   = (m_k[i] - 1) % T;
        exp_e = m_busy[i] && (off >= S) && (off < S + P);
        exp_d = (m_busy[i] && m_wr[i]) ? seg_dout(i, m_k[i]) : m_last[i];
        exp_w = (rd[i] | wr[i]) && (reset || !(m_busy[i] && m_k[i] == acc_len(i)));
        chk1("m_lcd_e", i, e[i], exp_e);
        chk1("m_lcd_oe", i, oe[i], m_busy[i] && m_wr[i]);
        chk1("m_lcd_rs", i, rs[i], m_rs[i]);
        chk1("m_lcd_rw", i, rw[i], m_rw[i]);
        chk8("m_data_out", i, dout[i], exp_d);
        chk8("m_readdata", i, rdata[i], m_rd[i]);
        chk1("m_waitrequest", i, waitr[i], exp_w);
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #4;
    k++;
  endtask

  task automatic start_access(input int i, input logic r, input logic w,
                              input logic [1:0] a, input logic [7:0] d);
    rd[i]   = r;
    wr[i]   = w;
    addr[i] = a;
    wd[i]   = d;
    k       = 0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 2'b00; wd[i] = 8'h00; din[i] = 8'h00;
    end
    wr[0] = 1'b1;
    adv();
    chk1("wait_in_reset", 0, waitr[0], 1'b1);
    chk8("rst_readdata", 0, rdata[0], 8'h00);
    chk1("rst_rw", 0, rw[0], 1'b1);
    chk8("rst_data_out", 1, dout[1], 8'h00);
    wr[0] = 1'b0;
    adv();
    reset = 1'b0;
    adv(); adv();

    // 8-bit write, RS=1, 0x41
    start_access(0, 1'b0, 1'b1, 2'b10, 8'h41);
    repeat (9) begin
      adv();
      if (k == 1) chk8("wr_dout_c1", 0, dout[0], 8'h41);
      if (k == 2) chk1("wr_e_c2", 0, e[0], 1'b0);
      if (k == 3) chk1("wr_e_c3", 0, e[0], 1'b1);
      if (k == 7) chk1("wr_wait_c7", 0, waitr[0], 1'b1);
      if (k == 8) chk1("wr_wait_c8", 0, waitr[0], 1'b0);
    end
    wr[0] = 1'b0;
    adv(); adv();

    // 8-bit read, 0x80 from pads
    din[0] = 8'h80;
    start_access(0, 1'b1, 1'b0, 2'b01, 8'h00);
    repeat (9) begin
      adv();
      if (k == 6) chk8("rd_rdata_c6", 0, rdata[0], 8'h00);
      if (k == 7) chk8("rd_rdata_c7", 0, rdata[0], 8'h80);
      if (k == 8) chk1("rd_wait_c8", 0, waitr[0], 1'b0);
    end
    rd[0] = 1'b0;
    adv(); adv();

    // 4-bit write 0x28
    start_access(1, 1'b0, 1'b1, 2'b00, 8'h28);
    repeat (17) begin
      adv();
      if (k == 4)  chk8("n_dout_c4", 1, dout[1], 8'h20);
      if (k == 12) chk8("n_dout_c12", 1, dout[1], 8'h80);
      if (k == 15) chk1("n_wait_c15", 1, waitr[1], 1'b1);
      if (k == 16) chk1("n_wait_c16", 1, waitr[1], 1'b0);
    end
    wr[1] = 1'b0;
    adv(); adv();

    // back-to-back writes 0x01 then 0x02
    start_access(0, 1'b0, 1'b1, 2'b00, 8'h01);
    repeat (18) begin
      adv();
      if (k == 9) begin
        chk8("b2b_dout_c9", 0, dout[0], 8'h01);
        wd[0] = 8'h02;
      end
      if (k == 10) chk8("b2b_dout_c10", 0, dout[0], 8'h02);
      if (k == 11) chk1("b2b_e_c11", 0, e[0], 1'b0);
      if (k == 12) chk1("b2b_e_c12", 0, e[0], 1'b1);
      if (k == 15) chk1("b2b_e_c15", 0, e[0], 1'b1);
      if (k == 16) chk1("b2b_e_c16", 0, e[0], 1'b0);
      if (k == 17) chk1("b2b_wait_c17", 0, waitr[0], 1'b0);
    end
    wr[0] = 1'b0;
    adv(); adv();

    // read and write together act as a write
    start_access(0, 1'b1, 1'b1, 2'b00, 8'h5A);
    repeat (9) begin
      adv();
      if (k == 1) begin
        chk1("rw_both_rw", 0, rw[0], 1'b0);
        chk1("rw_both_oe", 0, oe[0], 1'b1);
      end
      if (k == 8) chk1("rw_both_wait", 0, waitr[0], 1'b0);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    adv(); adv();

    // 4-bit read, pads change between nibbles
    din[1] = 8'hC5;
    start_access(1, 1'b1, 1'b0, 2'b10, 8'h00);
    repeat (17) begin
      adv();
      if (k == 7)  chk8("n_rd_c7", 1, rdata[1], 8'hC0);
      if (k == 8)  din[1] = 8'h3A;
      if (k == 15) chk8("n_rd_c15", 1, rdata[1], 8'hC3);
      if (k == 16) chk1("n_rd_wait_c16", 1, waitr[1], 1'b0);
    end
    rd[1] = 1'b0;
    adv(); adv();

    // read request withdrawn mid-access still completes
    din[0] = 8'h7E;
    start_access(0, 1'b1, 1'b0, 2'b11, 8'h00);
    repeat (10) begin
      adv();
      if (k == 2) rd[0] = 1'b0;
      if (k == 4) chk1("drop_rs", 0, rs[0], 1'b1);
      if (k == 7) chk8("drop_rdata", 0, rdata[0], 8'h7E);
    end

    // reset in the middle of the E pulse
    start_access(0, 1'b0, 1'b1, 2'b10, 8'h41);
    repeat (20) begin
      adv();
      if (k == 3) chk1("rst_mid_e_c3", 0, e[0], 1'b1);
      if (k == 4) begin
        reset = 1'b1;
        wr[0] = 1'b0;
      end
      if (k == 5) begin
        chk1("rst_mid_e", 0, e[0], 1'b0);
        chk1("rst_mid_oe", 0, oe[0], 1'b0);
        chk1("rst_mid_rw", 0, rw[0], 1'b1);
        reset = 1'b0;
      end
      if (k > 5 && e[0]) ehigh++;
    end
    chk1("no_e_after_reset", 0, ehigh != 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: clk cycles RS/RW valid before E rises (min 1).
REQ-002 SHALL have parameter PULSE_CYC, default 12: clk cycles E high (min 1).
REQ-003 SHALL have parameter HOLD_CYC, default 2: clk cycles E low after fall, with RS/RW/data still held (min 1).
REQ-004 SHALL have parameter BUS4, default 0: 0 = 8-bit LCD bus, 1 = 4-bit nibble mode on LCD_data[7:4].
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  bit0 = RW (1 read), bit1 = RS (1 data register).
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  8  byte to LCD.
- readdata  out  8  byte read from LCD, registered.
- waitrequest  out  1  Avalon stall.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/not-write.
- LCD_data_out  out  8  data to LCD pads.
- LCD_data_oe  out  1  pad output enable; tristate buffer lives at top level.
- LCD_data_in  in  8  data from LCD pads.

Function
REQ-006 SHALL implement FSM IDLE -> SETUP -> PULSE -> HOLD -> (IDLE | SETUP), with one down-counter sized for max(SETUP_CYC, PULSE_CYC, HOLD_CYC).
REQ-007 In IDLE with read|write high, SHALL latch address, writedata and direction, and enter SETUP next cycle.
- This acceptance cycle is cycle 0.
REQ-008 SHALL drive LCD_RS = latched address[1] and LCD_RW = latched direction from SETUP entry through HOLD end.
REQ-009 SHALL hold LCD_E high exactly PULSE_CYC cycles, in PULSE only; LCD_E SHALL be low in every other state.
REQ-010 For writes, SHALL drive LCD_data_oe=1 with stable data from SETUP entry through HOLD end; SHALL drive LCD_data_oe=0 in IDLE and in all read transactions.
REQ-011 For reads, SHALL sample LCD_data_in into readdata on the last PULSE cycle.
REQ-012 BUS4=0: one SETUP/PULSE/HOLD sequence per access.
REQ-013 BUS4=1: two sequences per access, back to back (HOLD -> SETUP), high nibble first.
- Write: LCD_data_out[7:4] = writedata[7:4], then writedata[3:0]; LCD_data_out[3:0] = 0.
- Read: readdata[7:4] from first pulse, readdata[3:0] from second.
REQ-014 waitrequest SHALL be combinational: (read|write) AND NOT (state==HOLD AND last HOLD cycle AND last nibble).
- Access completes on cycle 1+N*(SETUP_CYC+PULSE_CYC+HOLD_CYC)-1, with N = 1 or 2.
REQ-015 After the final HOLD cycle, SHALL return to IDLE; a request still asserted there SHALL start a new access, giving no idle gap beyond IDLE.
REQ-016 read and write both high at acceptance SHALL be treated as a write (LCD_RW=0).
REQ-017 If read/write drops mid-access, SHALL still complete the LCD sequence; readdata SHALL still update on reads.
REQ-018 Between accesses, LCD_RS/LCD_RW/LCD_data_out SHALL keep their last values; readdata SHALL change only per REQ-011.

Reset
REQ-019 reset sampled high SHALL, at that edge, force:
- state IDLE, counter 0;
- LCD_E=0, LCD_RS=0, LCD_RW=1;
- LCD_data_oe=0, LCD_data_out=0x00, readdata=0x00.
REQ-020 Reset mid-access SHALL abort at once, with no further E pulse, and SHALL not complete the access.
REQ-021 waitrequest SHALL equal read|write while in reset.

Verification (SETUP_CYC=2, PULSE_CYC=4, HOLD_CYC=2 unless stated)
REQ-022 BUS4=0, write addr=2, data=0x41 held until accepted:
- LCD_RS=1, LCD_RW=0, LCD_data_out=0x41, LCD_data_oe=1 on cycles 1-8;
- LCD_E high on cycles 3-6;
- waitrequest low on cycle 8 only.
REQ-023 BUS4=0, read addr=1, LCD_data_in=0x80:
- LCD_RW=1, LCD_data_oe=0 throughout;
- readdata=0x80 from cycle 7; waitrequest low on cycle 8.
REQ-024 BUS4=1, write addr=0, data=0x28:
- LCD_data_out[7:4]=0x2 during E pulse on cycles 3-6, then 0x8 during E pulse on cycles 11-14;
- waitrequest low on cycle 16.
REQ-025 Reset asserted on cycle 4 of REQ-022: LCD_E=0, LCD_data_oe=0, LCD_RW=1 after that edge, and no later E pulse.
REQ-026 read=write=1, addr=0:
- completes as a write with LCD_RW=0.
REQ-027 Two back-to-back writes 0x01, 0x02:
- second access accepted on cycle 9; second E pulse on cycles 12-15.
- LCD_data_out changes only at SETUP entry of the second access.
